// File: rtl/divide_iter.sv
// Multi-cycle unsigned divider c = a / b by Newton-Raphson refinement of 1/b,
// one iteration per clock, valid/ready on both sides, one operation in flight.
module divide_iter #(
  parameter int DATA_WD     = 8,
  parameter int DATA_INN_WD = 24,
  parameter int OUT_FRA_WD  = 8,
  parameter int NUMB_ITR    = 12
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          val_i,
  output logic                          rdy_o,
  input  logic [DATA_WD-1:0]            dat_a_i,
  input  logic [DATA_WD-1:0]            dat_b_i,
  output logic                          val_o,
  input  logic                          rdy_i,
  output logic [DATA_WD+OUT_FRA_WD-1:0] dat_c_o,
  output logic                          err_o
);

  localparam int TW   = DATA_INN_WD + 1;          // reciprocal t is I1F<DATA_INN_WD>
  localparam int KW   = DATA_INN_WD + 2;          // k = 2.0 - b*t needs one more integer bit
  localparam int PW   = TW + KW;
  localparam int FW   = DATA_WD + TW;
  localparam int CW   = DATA_WD + OUT_FRA_WD;
  localparam int CNTW = $clog2(NUMB_ITR + 1);

  localparam logic [TW-1:0] T_INIT = TW'(1) << (DATA_INN_WD - DATA_WD);
  localparam logic [KW-1:0] TWO    = KW'(1) << (DATA_INN_WD + 1);

  typedef enum logic [1:0] {IDLE, ITR, MUL, DONE} state_t;

  state_t               state_q;
  logic [CNTW-1:0]      cnt_q;
  logic [DATA_WD-1:0]   a_q;
  logic [DATA_WD-1:0]   b_q;
  logic [TW-1:0]        t_q;
  logic [TW-1:0]        t_d;
  logic [TW-1:0]        j;
  logic [KW-1:0]        k;
  logic [PW-1:0]        tk;
  logic [PW-1:0]        tk_rnd;
  logic [FW-1:0]        c_full;
  logic [FW-1:0]        q;
  logic [CW-1:0]        c_d;

  // One Newton step t' = t * (2 - b*t), rounded half up back to F<DATA_INN_WD>.
  assign j      = TW'(b_q) * t_q;
  assign k      = TWO - KW'(j);
  assign tk     = PW'(t_q) * PW'(k);
  assign tk_rnd = (tk >> (DATA_INN_WD - 1)) + PW'(1);
  assign t_d    = TW'(tk_rnd >> 1);

  assign c_full = FW'(a_q) * FW'(t_q);

  generate
    if (OUT_FRA_WD == DATA_INN_WD) begin : g_q_exact
      assign q = c_full;
    end else begin : g_q_rnd
      logic [FW-1:0] q_rnd;
      assign q_rnd = (c_full >> (DATA_INN_WD - OUT_FRA_WD - 1)) + FW'(1);
      assign q     = q_rnd >> 1;
    end
  endgenerate

  // Divide-by-zero and any quotient beyond the output range both pin to all-ones.
  assign c_d = (b_q == '0 || q > FW'({CW{1'b1}})) ? '1 : q[CW-1:0];

  assign rdy_o = (state_q == IDLE);

  // NOTE: all state below updates with <= so every register sees pre-edge values of the others.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      t_q     <= '0;
      val_o   <= 1'b0;
      dat_c_o <= '0;
      err_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (val_i) begin
            a_q     <= dat_a_i;
            b_q     <= dat_b_i;
            t_q     <= T_INIT;
            cnt_q   <= '0;
            state_q <= ITR;
          end
        end
        ITR: begin
          t_q   <= t_d;
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(NUMB_ITR - 1)) state_q <= MUL;
        end
        MUL: begin
          dat_c_o <= c_d;
          err_o   <= (b_q == '0);
          val_o   <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (rdy_i) begin
            val_o   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_iter.sv
// Bench for divide_iter: two instances (default and NUMB_ITR=14/OUT_FRA_WD=12) checked
// every cycle against an arithmetic reciprocal model plus hand-computed quotients.
module tb_divide_iter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        vi [2];
  logic        ri [2];
  logic [7:0]  ai [2];
  logic [7:0]  bi [2];
  logic        vo [2];
  logic        ro [2];
  logic        eo [2];
  logic [15:0] c0;
  logic [19:0] c1;
  logic [31:0] dc [2];

  assign dc[0] = {16'b0, c0};
  assign dc[1] = {12'b0, c1};

  always #5 clk = ~clk;

  divide_iter u_dut0 (
    .clk(clk), .rstn(rstn), .val_i(vi[0]), .rdy_o(ro[0]), .dat_a_i(ai[0]), .dat_b_i(bi[0]),
    .val_o(vo[0]), .rdy_i(ri[0]), .dat_c_o(c0), .err_o(eo[0])
  );

  divide_iter #(.NUMB_ITR(14), .OUT_FRA_WD(12)) u_dut1 (
    .clk(clk), .rstn(rstn), .val_i(vi[1]), .rdy_o(ro[1]), .dat_a_i(ai[1]), .dat_b_i(bi[1]),
    .val_o(vo[1]), .rdy_i(ri[1]), .dat_c_o(c1), .err_o(eo[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reciprocal refinement in I1F24 with plain integer arithmetic, then scaled and rounded quotient.
  function automatic longint model_q(input longint a, input longint b, input int itr,
                                     input int fra, output bit err);
    longint m25, t, j, k, c, q, sat;
    m25 = (longint'(1) << 25) - 1;
    t   = longint'(1) << 16;
    for (int i = 0; i < itr; i++) begin
      j = (b * t) & m25;
      k = (longint'(1) << 25) - j;
      t = ((((t * k) >> 23) + 1) >> 1) & m25;
    end
    c   = a * t;
    q   = ((c >> (23 - fra)) + 1) >> 1;
    sat = (longint'(1) << (8 + fra)) - 1;
    err = (b == 0);
    if (err || q > sat) q = sat;
    return q;
  endfunction

  function automatic int itr_of(input int d);
    return (d == 0) ? 12 : 14;
  endfunction

  function automatic int fra_of(input int d);
    return (d == 0) ? 8 : 12;
  endfunction

  // Per-instance scoreboard: one operation in flight, so scalars suffice.
  int     cyc = 0;
  bit     pend [2];
  int     acc [2];
  int     prev_acc [2];
  bit     prev_b2b [2];
  bit     b2b [2];
  longint expc [2];
  bit     expe [2];
  longint lit [2];
  longint lit_in [2];
  longint op_a [2];
  longint op_b [2];
  longint held_c [2];
  bit     held_e [2];
  bit     vo_prev [2];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rstn) begin
        check(vo[d] == 1'b0, "reset_val_o", vo[d], 0);
        check(ro[d] == 1'b1, "reset_rdy_o", ro[d], 1);
        check(dc[d] == 0, "reset_dat_c_o", dc[d], 0);
        check(eo[d] == 1'b0, "reset_err_o", eo[d], 0);
        pend[d]     = 1'b0;
        held_c[d]   = 0;
        held_e[d]   = 1'b0;
        prev_b2b[d] = 1'b0;
      end else begin
        if (vo[d] && !vo_prev[d]) begin
          if (!pend[d]) begin
            check(1'b0, "spurious_val_o", 1, 0);
          end else begin
            check(cyc - acc[d] == itr_of(d) + 1, "latency", cyc - acc[d], itr_of(d) + 1);
            check(longint'(dc[d]) == expc[d], "quotient", dc[d], expc[d]);
            check(eo[d] == expe[d], "err_o", eo[d], expe[d]);
            if (lit[d] >= 0) check(longint'(dc[d]) == lit[d], "literal", dc[d], lit[d]);
            if (op_b[d] != 0) begin
              longint ideal, diff;
              ideal = (op_a[d] << fra_of(d)) / op_b[d];
              diff  = longint'(dc[d]) - ideal;
              check(diff <= 1 && diff >= -1, "tolerance", dc[d], ideal);
            end
            pend[d] = 1'b0;
          end
          held_c[d] = longint'(dc[d]);
          held_e[d] = eo[d];
        end else begin
          check(longint'(dc[d]) == held_c[d], "hold_dat_c_o", dc[d], held_c[d]);
          check(eo[d] == held_e[d], "hold_err_o", eo[d], held_e[d]);
          if (pend[d] && cyc - acc[d] >= itr_of(d) + 1) begin
            check(1'b0, "val_o_timeout", cyc - acc[d], itr_of(d) + 1);
            pend[d] = 1'b0;
          end
        end
        check(ro[d] == !(pend[d] || vo[d]), "rdy_o", ro[d], !(pend[d] || vo[d]));
        if (vi[d] && ro[d]) begin
          bit e;
          pend[d] = 1'b1;
          acc[d]  = cyc + 1;
          op_a[d] = longint'(ai[d]);
          op_b[d] = longint'(bi[d]);
          expc[d] = model_q(op_a[d], op_b[d], itr_of(d), fra_of(d), e);
          expe[d] = e;
          lit[d]  = lit_in[d];
          if (b2b[d] && prev_b2b[d])
            check(acc[d] - prev_acc[d] == itr_of(d) + 3, "issue_interval",
                  acc[d] - prev_acc[d], itr_of(d) + 3);
          prev_acc[d] = acc[d];
          prev_b2b[d] = b2b[d];
        end
      end
      vo_prev[d] = vo[d];
    end
  end

  task automatic wait_rdy(input int d);
    int n = 0;
    while (!ro[d] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(ro[d] == 1'b1, "wait_rdy", ro[d], 1);
  endtask

  task automatic issue(input int d, input int a, input int b, input longint l);
    wait_rdy(d);
    ai[d]     = 8'(a);
    bi[d]     = 8'(b);
    lit_in[d] = l;
    vi[d]     = 1'b1;
    @(posedge clk); #1;
    vi[d] = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e;
    longint m;
    for (int d = 0; d < 2; d++) begin
      vi[d] = 1'b0; ri[d] = 1'b1; ai[d] = '0; bi[d] = '0;
      b2b[d] = 1'b0; lit_in[d] = -1; pend[d] = 1'b0; vo_prev[d] = 1'b0;
    end

    // Pin the model itself with hand-computed quotients.
    m = model_q(6, 3, 12, 8, e);    check(m == 'h0200, "model_6_3", m, 'h0200);
    m = model_q(1, 3, 12, 8, e);    check(m == 'h0055, "model_1_3", m, 'h0055);
    m = model_q(255, 1, 12, 8, e);  check(m == 'hFF00, "model_255_1", m, 'hFF00);
    m = model_q(17, 0, 12, 8, e);   check(m == 'hFFFF && e, "model_17_0", m, 'hFFFF);
    m = model_q(200, 7, 12, 8, e);  check(m == 'h1C92, "model_200_7", m, 'h1C92);
    m = model_q(1, 3, 14, 12, e);   check(m == 'h555, "model_1_3_f12", m, 'h555);

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check(ro[0] == 1'b1, "rdy_after_reset", ro[0], 1);

    // Directed operands on the default instance.
    issue(0, 6, 3, 'h0200);
    issue(0, 1, 3, 'h0055);
    issue(0, 255, 1, 'hFF00);
    issue(0, 17, 0, 'hFFFF);
    issue(0, 255, 255, 'h0100);
    issue(0, 0, 5, 'h0000);
    issue(0, 9, 4, 'h0240);
    wait_rdy(0);

    // Back-pressure: result held while rdy_i is low, new operands ignored.
    ri[0] = 1'b0;
    issue(0, 100, 9, 'h0B1C);
    for (int n = 0; n < 40 && !vo[0]; n++) begin @(posedge clk); #1; end
    check(vo[0] == 1'b1, "val_o_before_stall", vo[0], 1);
    ai[0] = 8'd5; bi[0] = 8'd1; vi[0] = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    check(vo[0] == 1'b1 && ro[0] == 1'b0, "stalled_state", {vo[0], ro[0]}, 2);
    vi[0] = 1'b0;
    ri[0] = 1'b1;
    @(posedge clk); #1;
    check(ro[0] == 1'b1, "rdy_after_release", ro[0], 1);

    // Reset mid-operation aborts it.
    issue(0, 50, 5, -1);
    repeat (4) begin @(posedge clk); #1; end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check(ro[0] == 1'b1, "rdy_after_abort", ro[0], 1);
    repeat (20) begin @(posedge clk); #1; end
    check(vo[0] == 1'b0, "no_val_after_abort", vo[0], 0);
    issue(0, 200, 7, 'h1C92);
    wait_rdy(0);

    // Back-to-back random operations.
    b2b[0] = 1'b1;
    for (int i = 0; i < 20; i++) issue(0, $urandom_range(255, 1), $urandom_range(255, 1), -1);
    wait_rdy(0);
    b2b[0] = 1'b0;

    // Second configuration: 14 iterations, 12 fraction bits.
    issue(1, 6, 3, 'h02000);
    issue(1, 1, 3, 'h00555);
    issue(1, 255, 1, 'hFF000);
    issue(1, 17, 0, 'hFFFFF);
    wait_rdy(1);
    b2b[1] = 1'b1;
    for (int i = 0; i < 10; i++) issue(1, $urandom_range(255, 1), $urandom_range(255, 1), -1);
    wait_rdy(1);
    b2b[1] = 1'b0;

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
